mult16u_rr_scheduler: RTL

//   Shares one pipelined 16x16 unsigned multiplier among NUM_REQ requesters.

---
 rtl/mult16u_rr_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult16u_rr_scheduler.sv
// Round-robin front end that shares one pipelined unsigned multiplier among NUM_REQ clients.
// Issue is credit-limited so every product always finds a slot in the in-order response FIFO.
module mult16u_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 16,
  parameter int MULT_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       mul_valid,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0]        rr_ptr_r;
  logic                 mul_valid_r;
  logic [WIDTH-1:0]     mul_a_r;
  logic [WIDTH-1:0]     mul_b_r;
  logic [MULT_LATENCY:0] tag_vld_r;
  logic [IW-1:0]        tag_id_r [MULT_LATENCY+1];
  logic [2*WIDTH-1:0]   data_mem_r [FIFO_DEPTH];
  logic [IW-1:0]        id_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        inflight_r;
  logic                 can_issue_s;
  logic                 found_s;
  logic                 hit_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 rsp_valid_s;
  logic [IW-1:0]        idx_s;
  logic [IW-1:0]        grant_id_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // A same-cycle pop frees its credit only once count_r has updated
  assign can_issue_s = ({1'b0, inflight_r} + {1'b0, count_r}) < (CW+1)'(FIFO_DEPTH);
  assign accept_s    = found_s && can_issue_s && !rst;
  assign push_s      = tag_vld_r[MULT_LATENCY];
  assign rsp_valid_s = (count_r != '0);
  assign pop_s       = rsp_valid_s && rsp_ready;

  // Round-robin search for the first valid requester starting at rr_ptr_r
  always_comb begin
    found_s    = 1'b0;
    hit_s      = 1'b0;
    idx_s      = '0;
    grant_id_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s      = IW'((int'(rr_ptr_r) + k) % NUM_REQ);
      hit_s      = !found_s && req_valid[idx_s];
      grant_id_s = hit_s ? idx_s : grant_id_s;
      found_s    = found_s | hit_s;
    end
  end

  // One-hot accept strobe toward the granted requester
  always_comb begin
    req_ready_s = '0;
    if (accept_s) begin
      req_ready_s[grant_id_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Operand register, round-robin pointer and the id/valid tag pipe tracking the multiplier
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      mul_valid_r <= 1'b0;
      mul_a_r     <= '0;
      mul_b_r     <= '0;
      tag_vld_r   <= '0;
      for (int k = 0; k <= MULT_LATENCY; k++) tag_id_r[k] <= '0;
    end else begin
      mul_valid_r <= accept_s;
      tag_vld_r   <= {tag_vld_r[MULT_LATENCY-1:0], accept_s};
      tag_id_r[0] <= grant_id_s;
      for (int k = 1; k <= MULT_LATENCY; k++) tag_id_r[k] <= tag_id_r[k-1];
      if (accept_s) begin
        mul_a_r  <= req_a[int'(grant_id_s)*WIDTH +: WIDTH];
        mul_b_r  <= req_b[int'(grant_id_s)*WIDTH +: WIDTH];
        rr_ptr_r <= (grant_id_s == IW'(NUM_REQ-1)) ? '0 : grant_id_s + IW'(1);
      end
    end
  end

  // Requests accepted but not yet written into the response FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
    end else begin
      case ({accept_s, push_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Response FIFO; push into an empty FIFO becomes visible the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        data_mem_r[k] <= '0;
        id_mem_r[k]   <= '0;
      end
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= mul_p;
        id_mem_r[wr_ptr_r]   <= tag_id_r[MULT_LATENCY];
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit accounting must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (rst) !(push_s && (count_r == CW'(FIFO_DEPTH))));

  assign req_ready = req_ready_s;
  assign mul_valid = mul_valid_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign rsp_valid = rsp_valid_s;
  assign rsp_data  = data_mem_r[rd_ptr_r];
  assign rsp_id    = id_mem_r[rd_ptr_r];

endmodule
